// File: rtl/bsg_mesh_injector_pkg.sv
// Shared types and constants for the mesh packet injector: FSM states,
// packet field offsets and the 16-bit Galois LFSR step.
package bsg_mesh_injector_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } injector_state_e;

   localparam int lfsr_width_c = 16;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   localparam logic [lfsr_width_c-1:0] lfsr_taps_c = 16'hB400;

   localparam int rand_dest_y_lsb_c = 8;

   function automatic int dest_x_lo(input int x_w, input int y_w);
      return 0 * (x_w + y_w);
   endfunction

   function automatic int dest_y_lo(input int x_w);
      return x_w;
   endfunction

   function automatic int src_x_lo(input int x_w, input int y_w);
      return x_w + y_w;
   endfunction

   function automatic int src_y_lo(input int x_w, input int y_w);
      return 2 * x_w + y_w;
   endfunction

   function automatic int seq_lo(input int x_w, input int y_w);
      return 2 * (x_w + y_w);
   endfunction

   function automatic logic [lfsr_width_c-1:0] lfsr_step(input logic [lfsr_width_c-1:0] s);
      return {1'b0, s[lfsr_width_c-1:1]} ^ (s[0] ? lfsr_taps_c : '0);
   endfunction

endpackage

// File: rtl/bsg_mesh_injector_lfsr.sv
// 16-bit Galois LFSR used for random destinations; exposes both the current
// value and the value it will hold after the next advance.
module bsg_mesh_injector_lfsr
   import bsg_mesh_injector_pkg::*;
#(
   parameter logic [lfsr_width_c-1:0] seed_p = 16'hACE1
)
(
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    adv_i,
   output logic [lfsr_width_c-1:0] state_o,
   output logic [lfsr_width_c-1:0] next_o
);

   logic [lfsr_width_c-1:0] lfsr_r;

   assign next_o  = lfsr_step(lfsr_r);
   assign state_o = lfsr_r;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         lfsr_r <= seed_p;
      else if (adv_i)
         lfsr_r <= next_o;
   end

endmodule

// File: rtl/bsg_mesh_packet_injector.sv
// Valid/yumi traffic source for a mesh router port. Optional stall watchdog
// enabled by defining BSG_MESH_INJECTOR_TIMEOUT_EN.
module bsg_mesh_packet_injector
   import bsg_mesh_injector_pkg::*;
#(
   parameter int              width_p        = 32,
   parameter int              x_cord_width_p = 4,
   parameter int              y_cord_width_p = 4,
   parameter int              seq_width_p    = 8,
   parameter int              count_width_p  = 16,
   parameter logic [15:0]     lfsr_seed_p    = 16'hACE1,
   parameter int              timeout_p      = 1024
)
(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      en_i,
   input  logic                      mode_i,
   input  logic [x_cord_width_p-1:0] my_x_i,
   input  logic [y_cord_width_p-1:0] my_y_i,
   input  logic [x_cord_width_p-1:0] dest_x_i,
   input  logic [y_cord_width_p-1:0] dest_y_i,
   input  logic [count_width_p-1:0]  num_packets_i,
   input  logic [count_width_p-1:0]  gap_i,
   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   input  logic                      yumi_i,
   output logic                      done_o,
   output logic [count_width_p-1:0]  sent_count_o,
   output logic                      timeout_o
);

   localparam int dest_x_lo_lp = dest_x_lo(x_cord_width_p, y_cord_width_p);
   localparam int dest_y_lo_lp = dest_y_lo(x_cord_width_p);
   localparam int src_x_lo_lp  = src_x_lo(x_cord_width_p, y_cord_width_p);
   localparam int src_y_lo_lp  = src_y_lo(x_cord_width_p, y_cord_width_p);
   localparam int seq_lo_lp    = seq_lo(x_cord_width_p, y_cord_width_p);

   localparam logic [count_width_p-1:0] count_one_lp = count_width_p'(1);

   injector_state_e              state_r;
   logic [width_p-1:0]           data_r;
   logic [count_width_p-1:0]     sent_count_r;
   logic [count_width_p-1:0]     num_r;
   logic [count_width_p-1:0]     gap_r;
   logic [count_width_p-1:0]     gap_cnt_r;
   logic                         mode_r;
   logic [x_cord_width_p-1:0]    dest_x_r;
   logic [y_cord_width_p-1:0]    dest_y_r;
   logic [x_cord_width_p-1:0]    my_x_r;
   logic [y_cord_width_p-1:0]    my_y_r;

   logic [lfsr_width_c-1:0]      lfsr_q;
   logic [lfsr_width_c-1:0]      lfsr_next;
   logic                         accept;
   logic [count_width_p-1:0]     count_inc;
   logic [x_cord_width_p-1:0]    start_dx;
   logic [y_cord_width_p-1:0]    start_dy;
   logic [x_cord_width_p-1:0]    next_dx;
   logic [y_cord_width_p-1:0]    next_dy;
   logic                         unused_lfsr;

   function automatic logic [width_p-1:0] build_packet(
      input logic [x_cord_width_p-1:0] dx,
      input logic [y_cord_width_p-1:0] dy,
      input logic [x_cord_width_p-1:0] sx,
      input logic [y_cord_width_p-1:0] sy,
      input logic [count_width_p-1:0]  count
   );
      logic [width_p-1:0] pkt;
      pkt = '0;
      pkt[dest_x_lo_lp +: x_cord_width_p] = dx;
      pkt[dest_y_lo_lp +: y_cord_width_p] = dy;
      pkt[src_x_lo_lp  +: x_cord_width_p] = sx;
      pkt[src_y_lo_lp  +: y_cord_width_p] = sy;
      pkt[seq_lo_lp    +: seq_width_p]    = seq_width_p'(count);
      return pkt;
   endfunction

   assign accept    = (state_r == SEND) && yumi_i;
   assign count_inc = (&sent_count_r) ? sent_count_r : sent_count_r + count_one_lp;

   bsg_mesh_injector_lfsr #(
      .seed_p (lfsr_seed_p)
   ) lfsr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .adv_i   (accept),
      .state_o (lfsr_q),
      .next_o  (lfsr_next)
   );

   // Packet 0 takes its destination from the current LFSR value; every later
   // packet is built on the accepting edge from the value the LFSR moves to.
   assign start_dx = mode_i ? lfsr_q[x_cord_width_p-1:0] : dest_x_i;
   assign start_dy = mode_i ? lfsr_q[rand_dest_y_lsb_c +: y_cord_width_p] : dest_y_i;
   assign next_dx  = mode_r ? lfsr_next[x_cord_width_p-1:0] : dest_x_r;
   assign next_dy  = mode_r ? lfsr_next[rand_dest_y_lsb_c +: y_cord_width_p] : dest_y_r;

   assign unused_lfsr = ^{lfsr_q, lfsr_next};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r      <= IDLE;
         data_r       <= '0;
         sent_count_r <= '0;
         num_r        <= '0;
         gap_r        <= '0;
         gap_cnt_r    <= '0;
         mode_r       <= 1'b0;
         dest_x_r     <= '0;
         dest_y_r     <= '0;
         my_x_r       <= '0;
         my_y_r       <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (en_i) begin
                  sent_count_r <= '0;
                  if (num_packets_i == '0) begin
                     state_r <= DONE;
                  end else begin
                     mode_r   <= mode_i;
                     dest_x_r <= dest_x_i;
                     dest_y_r <= dest_y_i;
                     my_x_r   <= my_x_i;
                     my_y_r   <= my_y_i;
                     num_r    <= num_packets_i;
                     gap_r    <= gap_i;
                     data_r   <= build_packet(start_dx, start_dy, my_x_i, my_y_i, '0);
                     state_r  <= SEND;
                  end
               end
            end
            SEND: begin
               if (yumi_i) begin
                  sent_count_r <= count_inc;
                  if (count_inc == num_r) begin
                     state_r <= DONE;
                  end else begin
                     data_r <= build_packet(next_dx, next_dy, my_x_r, my_y_r, count_inc);
                     if (gap_r != '0) begin
                        gap_cnt_r <= gap_r - count_one_lp;
                        state_r   <= GAP;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_cnt_r == '0)
                  state_r <= SEND;
               else
                  gap_cnt_r <= gap_cnt_r - count_one_lp;
            end
            DONE: begin
               if (!en_i)
                  state_r <= IDLE;
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign v_o          = (state_r == SEND);
   assign done_o       = (state_r == DONE);
   assign data_o       = data_r;
   assign sent_count_o = sent_count_r;

`ifdef BSG_MESH_INJECTOR_TIMEOUT_EN
   localparam int stall_width_lp = $clog2(timeout_p + 1);
   localparam logic [stall_width_lp-1:0] stall_limit_lp = stall_width_lp'(timeout_p);

   logic [stall_width_lp-1:0] stall_cnt_r;
   logic                      timeout_r;

   // Counts consecutive stalled valid cycles; the flag stays set until reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_r <= '0;
         timeout_r   <= 1'b0;
      end else begin
         if ((state_r == SEND) && !yumi_i) begin
            if (stall_cnt_r != stall_limit_lp)
               stall_cnt_r <= stall_cnt_r + stall_width_lp'(1);
         end else begin
            stall_cnt_r <= '0;
         end
         if (stall_cnt_r == stall_limit_lp)
            timeout_r <= 1'b1;
      end
   end

   assign timeout_o = timeout_r;
`else
   localparam int unused_timeout_lp = timeout_p;
   assign timeout_o = 1'b0;
`endif

endmodule
